bus_sram_responder: RTL
=======================

# bus_sram_responder

Word-wide memory responder for the CPU data bus. It sits on the far side of the MMU-fronted bus and answers `MEM_ACCESS` requests from the CPU/MMU initiator with a programmable number of wait states. It serves read, write and execute accesses from an internal word array. It always sees whole-word accesses, because the initiator performs byte and halfword stores as a read followed by a write-back.

## Interface
- `ADDR_BITS`, 10: log2 of array depth in words; the array holds 2^ADDR_BITS × 32 bits.
- `BASE_ADDR`, 32'h0000_0000: physical byte address of word 0; must be aligned to 4·2^ADDR_BITS.
- `WAIT_CYCLES`, 2: extra cycles between request and `db_ready`; legal range 0..15.
- `clk`  in  1  clock; one clock domain.
- `res`  in  1  synchronous, active-high reset.
- `db_addr`  in  32  physical byte address; bits [1:0] are ignored.
- `db_dataIn`  in  32  write data from the initiator.
- `db_accessType`  in  `MEM_ACCESS` (DataBus.vh)  request type: `MEM_ACCESS_NONE`/`_R`/`_W`/`_X`.
- `db_dataOut`  out  32  read data returned to the initiator.
- `db_ready`  out  1  one-cycle completion strobe.
- `db_busErr`  out  1  asserted together with `db_ready` when the address is out of range.

## Operation
- A request is a single-cycle pulse: any cycle with `db_accessType != MEM_ACCESS_NONE` is a request. `db_addr` and `db_dataIn` are valid only in that cycle, so the block latches address, type and write data on the pulse.
- `_X` is handled exactly like `_R`.
- In range means `db_addr - BASE_ADDR < 4·2^ADDR_BITS`. Index = `(db_addr - BASE_ADDR)[ADDR_BITS+1:2]`.
- States:
  - IDLE: on a request, go to BUSY and load counter := WAIT_CYCLES.
  - BUSY: counter decrements each cycle. In the cycle after the counter reads 0, go to IDLE and pulse `db_ready`.
  - A request in any state restarts BUSY with the new request.
- Write commit happens in the `db_ready` cycle, not on the pulse. Out-of-range writes are dropped.
- Abort: a new request arriving while BUSY discards the pending access. The pending access produces no `db_ready`, and a pending write is not committed. This case occurs when the initiator abandons an access on an MMU exception and reissues a request 2 cycles later.
- Read data:
  - `db_dataOut` is driven with the array word (or 32'h0 when out of range) in the `db_ready` cycle of a read.
  - It holds that value until the next read completes.
  - Writes do not change `db_dataOut`.
- `db_busErr` pulses with `db_ready` for an out-of-range access; otherwise it is 0.
- Array contents are not reset.

## Timing
- Reset values: `db_ready`=0, `db_busErr`=0, `db_dataOut`=32'h0, state IDLE, counter 0.
- Reset mid-access discards the pending access: no `db_ready`, no write commit.
- Latency: for a request in cycle c, `db_ready` is high in cycle c+1+WAIT_CYCLES, for exactly one cycle. `db_dataOut` is valid in that cycle.
- Read-modify-write handshake: the initiator may issue a `_W` request in the same cycle it samples `db_ready` for the preceding `_R`, with the write data built combinationally from `db_dataOut`. Therefore:
  - `db_dataOut` stays stable through that cycle and afterwards.
  - The new request is accepted in the same cycle that `db_ready` is high.
  - `db_ready` deasserts in the next cycle unless WAIT_CYCLES=0.
- WAIT_CYCLES=0 with back-to-back requests: `db_ready` is high in every cycle following a request.
- Reads observe all writes committed in earlier cycles. A read completing in the same cycle as a write commit is impossible, because only one access is outstanding at a time.
- Every output is registered; there are no combinational paths from inputs to outputs.

## Test plan
- Read with WAIT_CYCLES=2, BASE 0: preload word 5 = 32'hDEADBEEF; `_R` pulse at addr 0x14 in cycle 10 → `db_ready`=1 only in cycle 13, `db_dataOut`=32'hDEADBEEF held through cycle 20, `db_busErr`=0.
- Write then execute: `_W` 0x20 data 32'h12345678, wait for `db_ready`, then `_X` 0x23 → second `db_ready` returns 32'h12345678 (bits [1:0] ignored).
- RMW: word 2 = 32'hAABBCCDD; `_R` 0x08; in the `db_ready` cycle pulse `_W` 0x08 with {8'h11, `db_dataOut`[23:0]} → after the next `db_ready`, reading 0x08 gives 32'h11BBCCDD; `db_dataOut` is unchanged during the write.
- Abort: `_W` 0x30 data 32'hFFFFFFFF at cycle c, `_R` 0x30 at c+2 (WAIT_CYCLES=2) → exactly one `db_ready`, at c+5, returning the old contents; the write is never committed.
- Out of range (ADDR_BITS=10): `_R` at 0x1000 → `db_ready` and `db_busErr` both high after 3 cycles, data 32'h0; `_W` at 0x1000 leaves the array unchanged.
- Reset: assert `res` one cycle after a `_W` pulse → no `db_ready`, target word unchanged, all outputs 0 in the cycle after reset.

Source files
------------

// File: rtl/bus_sram_responder.sv
// bus_sram_responder: word-wide memory responder for the CPU data bus.
// Each MEM_ACCESS pulse is latched, held for WAIT_CYCLES wait states and then
// completed with a one-cycle db_ready strobe. A newer pulse always replaces a
// pending access, which then produces no strobe and no write.
//
// Handshake: a request is any cycle with db_accessType != MEM_ACCESS_NONE and
// is accepted unconditionally in that cycle. db_ready is high for exactly one
// cycle, c+1+WAIT_CYCLES for a request in cycle c. db_dataOut and db_busErr are
// valid in that cycle. db_dataOut then holds its value until the next read
// completes.

package bus_sram_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_NONE = 2'd0,
        MEM_ACCESS_R    = 2'd1,
        MEM_ACCESS_W    = 2'd2,
        MEM_ACCESS_X    = 2'd3
    } mem_access_t;
endpackage

module bus_sram_responder
    import bus_sram_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] db_addr,
    input  logic [31:0] db_dataIn,
    input  mem_access_t db_accessType,
    output logic [31:0] db_dataOut,
    output logic        db_ready,
    output logic        db_busErr
);

    localparam int         DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    // With no wait states the access completes on the request edge itself,
    // so completion uses the live bus inputs instead of the latched copy.
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  w_done;

    // Decode of the request currently on the bus.
    logic                  w_req;
    logic                  w_req_write;
    logic [31:0]           w_req_off;
    logic                  w_req_in_range;
    logic [ADDR_BITS-1:0]  w_req_idx;

    // Pending access captured on the request pulse.
    logic                  r_pend_write;
    logic                  r_pend_in_range;
    logic [ADDR_BITS-1:0]  r_pend_idx;
    logic [31:0]           r_pend_wdata;

    // Access being completed this cycle.
    logic                  w_src_write;
    logic                  w_src_in_range;
    logic [ADDR_BITS-1:0]  w_src_idx;
    logic [31:0]           w_src_wdata;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_data_out;
    logic                  r_ready;
    logic                  r_bus_err;

    // _X is served exactly like _R, so only writes need to be told apart.
    assign w_req          = (db_accessType != MEM_ACCESS_NONE);
    assign w_req_write    = (db_accessType == MEM_ACCESS_W);
    assign w_req_off      = db_addr - BASE_ADDR;
    assign w_req_in_range = ((w_req_off >> (ADDR_BITS + 2)) == 32'd0);
    assign w_req_idx      = w_req_off[ADDR_BITS+1:2];

    assign w_src_write    = ZERO_WAIT ? w_req_write    : r_pend_write;
    assign w_src_in_range = ZERO_WAIT ? w_req_in_range : r_pend_in_range;
    assign w_src_idx      = ZERO_WAIT ? w_req_idx      : r_pend_idx;
    assign w_src_wdata    = ZERO_WAIT ? db_dataIn      : r_pend_wdata;

    // State and wait counter register.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: a new request always wins over finishing the pending one.
    // The counter is loaded with WAIT_CYCLES and the access completes on the
    // edge leaving count 1, which places db_ready at c+1+WAIT_CYCLES.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done       = 1'b0;
        if (w_req) begin
            if (ZERO_WAIT) begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
                w_cnt_next   = 4'd0;
            end else begin
                w_state_next = ST_BUSY;
                w_cnt_next   = WAIT_LOAD;
            end
        end else if (r_state == ST_BUSY) begin
            if (r_cnt <= 4'd1) begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
                w_cnt_next   = 4'd0;
            end else begin
                w_cnt_next   = r_cnt - 4'd1;
            end
        end
    end

    // Capture address, type and write data on the request pulse.
    always_ff @(posedge clk) begin
        if (res) begin
            r_pend_write    <= 1'b0;
            r_pend_in_range <= 1'b0;
            r_pend_idx      <= '0;
            r_pend_wdata    <= 32'h0;
        end else if (w_req) begin
            r_pend_write    <= w_req_write;
            r_pend_in_range <= w_req_in_range;
            r_pend_idx      <= w_req_idx;
            r_pend_wdata    <= db_dataIn;
        end
    end

    // Write commit on completion; out-of-range and reset-killed writes drop.
    always_ff @(posedge clk) begin
        if (!res && w_done && w_src_write && w_src_in_range) begin
            r_mem[w_src_idx] <= w_src_wdata;
        end
    end

    // Registered completion strobe, bus error and held read data.
    always_ff @(posedge clk) begin
        if (res) begin
            r_ready    <= 1'b0;
            r_bus_err  <= 1'b0;
            r_data_out <= 32'h0;
        end else begin
            r_ready   <= w_done;
            r_bus_err <= w_done && !w_src_in_range;
            if (w_done && !w_src_write) begin
                r_data_out <= w_src_in_range ? r_mem[w_src_idx] : 32'h0;
            end
        end
    end

    assign db_dataOut = r_data_out;
    assign db_ready   = r_ready;
    assign db_busErr  = r_bus_err;

endmodule
